// File: rtl/fp_mul_seq.sv
// fp_mul_seq - sequential IEEE-754 style floating-point multiplier.
//
// Significands are multiplied with an iterative radix-2 shift-add (one
// multiplier bit per cycle), then normalised and rounded to nearest-even.
// Subnormal inputs are flushed to zero; results that fall below the normal
// range are flushed to zero as well. NaN and Inf x 0 produce a canonical qNaN.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  operands {sign, exponent, mantissa}
//   out_valid / out_ready result handshake
//   result                product
//   overflow              finite operands rounded to +/-Inf
//   underflow             non-zero finite operands flushed to +/-0
//   exception             invalid operation, result is canonical qNaN
//   inexact               non-zero bits were discarded
//   dbg_state             current FSM state (IDLE=0, MUL=1, RND=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Operands are only sampled on that edge. Once out_valid rises, result
// and flags stay frozen until the edge where out_valid & out_ready are high.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception,
  output logic                   inexact,
  output logic [1:0]             dbg_state
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 1;      // significand width incl. hidden bit
  localparam int P     = 2 * N;          // product width
  localparam int CNT_W = $clog2(N);

  localparam logic [EXP_W-1:0]       EXP_ONES = '1;
  localparam logic signed [EXP_W+1:0] E_BIAS  = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EXP_W+1:0] E_INF   = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] E_ZERO  = '0;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(MAN_W);
  localparam logic [W-1:0]           QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_RND = 2'd2, S_DONE = 2'd3} state_t;

  state_t state_q, state_d;

  // Operand classification (only meaningful in the acceptance cycle)
  logic [EXP_W-1:0] ea_in, eb_in;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic             sign_in, special_in, invalid_in;
  logic [W-1:0]     spec_result;

  assign ea_in  = a[W-2 -: EXP_W];
  assign eb_in  = b[W-2 -: EXP_W];
  assign nan_a  = (ea_in == EXP_ONES) && (a[MAN_W-1:0] != '0);
  assign nan_b  = (eb_in == EXP_ONES) && (b[MAN_W-1:0] != '0);
  assign inf_a  = (ea_in == EXP_ONES) && (a[MAN_W-1:0] == '0);
  assign inf_b  = (eb_in == EXP_ONES) && (b[MAN_W-1:0] == '0);
  assign zero_a = (ea_in == '0);
  assign zero_b = (eb_in == '0);
  assign sign_in    = a[W-1] ^ b[W-1];
  assign special_in = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
  assign invalid_in = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);

  always_comb begin
    spec_result = {sign_in, {(W-1){1'b0}}};
    if (invalid_in)
      spec_result = QNAN;
    else if (inf_a | inf_b)
      spec_result = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
  end

  // Datapath registers
  logic             sign_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [P-1:0]     mcand_q, acc_q;
  logic [N-1:0]     mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     result_q;
  logic             ovf_q, unf_q, exc_q, inx_q;

  // Normalise + round (evaluated while in RND)
  logic                     norm, guard, sticky, inc, carry;
  logic [MAN_W-1:0]         man_t;
  logic [MAN_W:0]           man_r;
  logic signed [EXP_W+1:0]  e_sum;
  logic [W-1:0]             rnd_result;
  logic                     rnd_ovf, rnd_unf, rnd_inx;

  always_comb begin
    norm = acc_q[P-1];
    if (norm) begin
      man_t  = acc_q[P-2 -: MAN_W];
      guard  = acc_q[MAN_W];
      sticky = |acc_q[MAN_W-1:0];
    end else begin
      man_t  = acc_q[P-3 -: MAN_W];
      guard  = acc_q[MAN_W-1];
      sticky = |acc_q[MAN_W-2:0];
    end
    inc   = guard & (sticky | man_t[0]);
    man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    // A carry means the mantissa was all ones; the renormalised mantissa is
    // then zero, which man_r[MAN_W-1:0] already holds.
    carry = man_r[MAN_W];
    e_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - E_BIAS
          + $signed({{(EXP_W+1){1'b0}}, norm}) + $signed({{(EXP_W+1){1'b0}}, carry});

    rnd_result = {sign_q, e_sum[EXP_W-1:0], man_r[MAN_W-1:0]};
    rnd_ovf    = 1'b0;
    rnd_unf    = 1'b0;
    rnd_inx    = guard | sticky;
    if (e_sum >= E_INF) begin
      rnd_result = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      rnd_ovf    = 1'b1;
      rnd_inx    = 1'b1;
    end else if (e_sum <= E_ZERO) begin
      rnd_result = {sign_q, {(W-1){1'b0}}};
      rnd_unf    = 1'b1;
      rnd_inx    = 1'b1;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = special_in ? S_DONE : S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_RND;
      S_RND:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q   <= sign_in;
            ea_q     <= ea_in;
            eb_q     <= eb_in;
            mcand_q  <= {{N{1'b0}}, 1'b1, a[MAN_W-1:0]};
            mplier_q <= {1'b1, b[MAN_W-1:0]};
            acc_q    <= '0;
            cnt_q    <= '0;
            if (special_in) begin
              result_q <= spec_result;
              ovf_q    <= 1'b0;
              unf_q    <= 1'b0;
              exc_q    <= invalid_in;
              inx_q    <= 1'b0;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_RND: begin
          result_q <= rnd_result;
          ovf_q    <= rnd_ovf;
          unf_q    <= rnd_unf;
          exc_q    <= 1'b0;
          inx_q    <= rnd_inx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;
  assign inexact   = inx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq - bench for fp_mul_seq at FP32 (8/23) and FP16 (5/10).
// Both instances share clock, reset and output handshake; sel16 picks which
// one receives in_valid and whose outputs are observed.
module tb_fp_mul_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        sel16 = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_w = '0, b_w = '0;

  logic        in_ready32, out_valid32, ov32, uf32, ex32, ix32;
  logic [31:0] result32;
  logic [1:0]  dbg32;
  logic        in_ready16, out_valid16, ov16, uf16, ex16, ix16;
  logic [15:0] result16;
  logic [1:0]  dbg16;

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel16), .in_ready(in_ready32),
    .a(a_w), .b(b_w),
    .out_valid(out_valid32), .out_ready(out_ready),
    .result(result32), .overflow(ov32), .underflow(uf32),
    .exception(ex32), .inexact(ix32), .dbg_state(dbg32)
  );

  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel16), .in_ready(in_ready16),
    .a(a_w[15:0]), .b(b_w[15:0]),
    .out_valid(out_valid16), .out_ready(out_ready),
    .result(result16), .overflow(ov16), .underflow(uf16),
    .exception(ex16), .inexact(ix16), .dbg_state(dbg16)
  );

  logic [31:0] result_w;
  logic [3:0]  flags_w;   // {overflow, underflow, exception, inexact}
  logic        in_ready_w, out_valid_w;
  assign result_w    = sel16 ? {16'h0, result16} : result32;
  assign flags_w     = sel16 ? {ov16, uf16, ex16, ix16} : {ov32, uf32, ex32, ix32};
  assign in_ready_w  = sel16 ? in_ready16 : in_ready32;
  assign out_valid_w = sel16 ? out_valid16 : out_valid32;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];   // {flags, result}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Exact integer product of the significands, rounded by comparing the
  // discarded remainder against one half ulp.
  function automatic void ref_mul(input int ew, input int mw,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] fl);
    longint unsigned emask, mmask, ea, eb, fa, fb, prod, q, rem, half;
    longint e;
    int sh;
    logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    emask = (64'd1 << ew) - 1;
    mmask = (64'd1 << mw) - 1;
    ea = (64'(a) >> mw) & emask;
    eb = (64'(b) >> mw) & emask;
    fa = 64'(a) & mmask;
    fb = 64'(b) & mmask;
    s  = a[ew+mw] ^ b[ew+mw];
    nan_a  = (ea == emask) && (fa != 0);
    nan_b  = (eb == emask) && (fb != 0);
    inf_a  = (ea == emask) && (fa == 0);
    inf_b  = (eb == emask) && (fb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    r  = '0;
    fl = 4'b0000;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      r  = 32'((emask << mw) | (64'd1 << (mw-1)));
      fl = 4'b0010;
    end else if (inf_a || inf_b) begin
      r = 32'((64'(s) << (ew+mw)) | (emask << mw));
    end else if (zero_a || zero_b) begin
      r = 32'(64'(s) << (ew+mw));
    end else begin
      prod = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
      e = longint'(ea) + longint'(eb) - ((longint'(1) << (ew-1)) - 1);
      if (prod >= (64'd1 << (2*mw+1))) begin
        sh = mw + 1;
        e++;
      end else begin
        sh = mw;
      end
      q    = prod >> sh;
      rem  = prod & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh-1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd2 << mw)) begin
        q = q >> 1;
        e++;
      end
      if (e >= longint'(emask)) begin
        r  = 32'((64'(s) << (ew+mw)) | (emask << mw));
        fl = 4'b1001;
      end else if (e <= 0) begin
        r  = 32'(64'(s) << (ew+mw));
        fl = 4'b0101;
      end else begin
        r  = 32'((64'(s) << (ew+mw)) | (64'(e) << mw) | (q & mmask));
        fl = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw, input int span);
    int unsigned emax, bias, e, m, s;
    emax = (1 << ew) - 1;
    bias = (1 << (ew-1)) - 1;
    s = $urandom_range(0, 1);
    case ($urandom_range(0, 9))
      0:       e = 0;
      1:       e = emax;
      2, 3:    e = $urandom_range(0, emax);
      default: e = bias + $urandom_range(0, 2*span) - span;
    endcase
    m = ($urandom_range(0, 7) == 0) ? 0 : ($urandom & ((1 << mw) - 1));
    return (s << (ew+mw)) | (e << mw) | m;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1 with the selected DUT idle. exp_lat counts edges
  // from the acceptance edge to the edge that raises out_valid.
  task automatic do_op(input logic s16, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic [3:0] exp_f,
                       input int exp_lat, input int hold, input string tag);
    int lat;
    logic [35:0] exp_item;
    logic [31:0] r0;
    logic [3:0]  f0;
    sel16 = s16;
    #0;
    check({tag, "_in_ready_idle"}, 32'(in_ready_w), 32'd1);
    a_w = a;
    b_w = b;
    in_valid = 1'b1;
    exp_q.push_back({exp_f, exp_r});
    @(posedge clk); #1;
    in_valid = 1'b0;
    // operands must be ignored after acceptance
    a_w = $urandom;
    b_w = $urandom;
    lat = 0;
    while (!out_valid_w && lat < 100) begin
      if (lat == 2) check({tag, "_in_ready_busy"}, 32'(in_ready_w), 32'd0);
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin a_w = $urandom; b_w = $urandom; end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    exp_item = exp_q.pop_front();
    check({tag, "_result"}, result_w, exp_item[31:0]);
    check({tag, "_flags"}, 32'(flags_w), 32'(exp_item[35:32]));
    r0 = result_w;
    f0 = flags_w;
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid_w), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready_w), 32'd0);
      check({tag, "_hold_result"}, result_w, r0);
      check({tag, "_hold_flags"}, 32'(flags_w), 32'(f0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid_w), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready_w), 32'd1);
  endtask

  task automatic rand_op_run(input logic s16, input int n);
    int ew, mw, span, lat;
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic [31:0] emask;
    ew   = s16 ? 5 : 8;
    mw   = s16 ? 10 : 23;
    span = s16 ? 8 : 40;
    emask = (32'd1 << ew) - 1;
    for (int i = 0; i < n; i++) begin
      a = rand_op(ew, mw, span);
      b = rand_op(ew, mw, span);
      ref_mul(ew, mw, a, b, r, f);
      if (((a >> mw) & emask) == 0 || ((a >> mw) & emask) == emask ||
          ((b >> mw) & emask) == 0 || ((b >> mw) & emask) == emask)
        lat = 0;
      else
        lat = mw + 2;
      do_op(s16, a, b, r, f, lat, (i % 7 == 3) ? 3 : 0, s16 ? "rnd16" : "rnd32");
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid32", 32'(out_valid32), 32'd0);
    check("reset_result32", result32, 32'd0);
    check("reset_flags32", 32'({ov32, uf32, ex32, ix32}), 32'd0);
    check("reset_valid16", 32'(out_valid16), 32'd0);
    check("reset_result16", 32'(result16), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ready32", 32'(in_ready32), 32'd1);
    check("reset_ready16", 32'(in_ready16), 32'd1);

    // FP32 directed
    do_op(1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 25, 0, "mul_1p5x2");
    do_op(1'b0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 25, 0, "mul_m2x3");
    do_op(1'b0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 25, 0, "rne_tie");
    do_op(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 25, 0, "rne_nontie");
    do_op(1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1001, 25, 0, "overflow");
    do_op(1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0101, 25, 0, "underflow");
    do_op(1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010, 0, 0, "inf_x_zero");
    do_op(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0, 0, "ninf_x_2");
    do_op(1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0010, 0, 0, "nan_in");
    do_op(1'b0, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 25, 0, "near_two_sq");
    do_op(1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 25, 10, "backpressure");

    // Reset in the middle of MUL
    sel16 = 1'b0;
    a_w = 32'h3FC00000;
    b_w = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid32), 32'd0);
    check("midrst_ready", 32'(in_ready32), 32'd1);
    check("midrst_result", result32, 32'd0);
    check("midrst_flags", 32'({ov32, uf32, ex32, ix32}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(out_valid32), 32'd0);
    end

    // FP16
    do_op(1'b1, 32'h00003E00, 32'h00004000, 32'h00004200, 4'b0000, 12, 0, "fp16_1p5x2");
    do_op(1'b1, 32'h00007C00, 32'h00000000, 32'h00007E00, 4'b0010, 0, 0, "fp16_inf_x_zero");

    // Randomized against the reference model
    rand_op_run(1'b0, 40);
    rand_op_run(1'b1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
